lzc_stream: RTL and testbench
=============================

// Module: lzc_stream
// PURPOSE
//  Streaming multi-word zero counter, successor to the single-mode LZC block.
//  Accepts a group of WORD words of WIDTH bits, one per handshake, treating the
//  group as one WORD*WIDTH-bit number (first word = most significant).
//  Reports leading-zero (MODE=0) or trailing-zero (MODE=1) count of the group.
//  Uses a valid/ready handshake on both sides; one-deep registered output.
// PARAMETERS
//  WIDTH  8                       bits per input word (>=2)
//  WORD   16                      words per group (>=2)
//  ZW     $clog2(WIDTH*WORD+1)    count width, derived; do not override
// PORTS
//  CLK      in   1      clock, all logic on rising edge
//  RST      in   1      synchronous active-high reset
//  IVALID   in   1      input word valid
//  IREADY   out  1      block can accept a word this cycle
//  DATA     in   WIDTH  input word
//  MODE     in   1      0=leading zeros, 1=trailing zeros; sampled on first word only
//  OVALID   out  1      result valid, held until accepted
//  OREADY   in   1      downstream accepts result
//  ZEROS    out  ZW     zero count of completed group, 0..WIDTH*WORD
//  ALLZERO  out  1      group was entirely zero (ZEROS==WIDTH*WORD)
// BEHAVIOUR
//  - Word accepted when IVALID&&IREADY. IREADY = !OVALID || OREADY (combinational).
//  - FSM: IDLE (no group open) -> ACC on first accepted word; ACC -> IDLE on the
//    accepted word with index WORD-1. Word index counter 0..WORD-1 wraps to 0.
//  - MODE latched on the index-0 word; MODE changes during ACC are ignored.
//  - Leading (MODE=0): found flag starts 0. Per word, if !found: word==0 -> cnt+=WIDTH;
//    else cnt+=lz(word), found=1. Once found, later words do not change cnt.
//  - Trailing (MODE=1): per word, word==0 -> cnt+=WIDTH; else cnt=tz(word) (restart).
//  - Last word folded in combinationally; ZEROS/ALLZERO/OVALID registered on the
//    same edge. Latency: OVALID=1 the cycle after the last word is accepted.
//  - Accumulator and found cleared when the group completes; the next word starts
//    a fresh group with no idle cycle.
//  - Output: OVALID&&OREADY with no new completion -> OVALID=0 next cycle,
//    ZEROS/ALLZERO hold last value. A completion in the same cycle as acceptance
//    loads the new result and OVALID stays 1.
//  - Backpressure: while OVALID&&!OREADY, IREADY=0, so no words are accepted and
//    no result is dropped or overwritten.
//  - IVALID=0 mid-group: state held indefinitely; no timeout.
//  - Reset (any time, incl. mid-group): OVALID=0, ZEROS=0, ALLZERO=0, FSM=IDLE,
//    index=0, cnt=0, found=0, latched mode=0. A partial group is discarded.
//  - Arithmetic is unsigned in ZW bits. The maximum WIDTH*WORD fits, so no overflow.
// TESTING (WIDTH=8, WORD=4, ZW=6; OREADY=1 unless stated)
//  1 MODE=0, words 00,00,1F,FF -> ZEROS=19, ALLZERO=0, OVALID 1 cycle after 4th word.
//  2 MODE=0, words 00,00,00,00 -> ZEROS=32, ALLZERO=1; MODE=1 same data -> 32, 1.
//  3 MODE=1, words 80,00,00,00 -> ZEROS=31; words 00,00,01,10 -> ZEROS=4.
//  4 MODE=0 on word 0, MODE=1 on words 1-3, data 40,FF,FF,FF -> ZEROS=1 (mode held).
//  5 OREADY=0, two back-to-back groups (A: 01,..->7; B: 00,00,00,80->24):
//    A held, IREADY=0 on B's word 0; release OREADY -> A then B, none lost.
//  6 RST pulse after 2 words of a group -> outputs 0; next 4 words 00,08,00,00
//    with MODE=0 -> ZEROS=12, proving the partial group was discarded.

Source files
------------

// File: rtl/lzc_stream.sv
// Streaming multi-word leading/trailing zero counter with a one-deep registered result.
// A group of WORD words (first word = most significant) is reduced to one zero count.
module lzc_stream #(
   parameter int WIDTH = 8,
   parameter int WORD  = 16,
   parameter int ZW    = $clog2(WIDTH*WORD+1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IVALID,
   output logic             IREADY,
   input  logic [WIDTH-1:0] DATA,
   input  logic             MODE,
   output logic             OVALID,
   input  logic             OREADY,
   output logic [ZW-1:0]    ZEROS,
   output logic             ALLZERO
);

   // state | meaning
   // IDLE  | no group open, next accepted word is index 0
   // ACC   | group open, accumulating words 1..WORD-1
   typedef enum logic {IDLE, ACC} state_t;

   localparam int IW = (WORD > 1) ? $clog2(WORD) : 1;
   localparam logic [ZW-1:0] TOTAL    = ZW'(WIDTH*WORD);
   localparam logic [ZW-1:0] WIDTH_Z  = ZW'(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORD-1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [ZW-1:0]   cnt_q, cnt_d;
   logic            found_q, found_d;
   logic            mode_q, mode_d;
   logic            ovalid_q, ovalid_d;
   logic [ZW-1:0]   zeros_q, zeros_d;
   logic            allzero_q, allzero_d;

   logic [ZW-1:0]   lz_v, tz_v;
   logic [ZW-1:0]   cnt_cur, cnt_nx;
   logic            found_cur, found_nx;
   logic            eff_mode, first, accept, last;

   assign IREADY  = !ovalid_q || OREADY;
   assign OVALID  = ovalid_q;
   assign ZEROS   = zeros_q;
   assign ALLZERO = allzero_q;

   // Later iterations win: highest set bit gives lz, lowest set bit gives tz.
   always_comb begin
      lz_v = WIDTH_Z;
      tz_v = WIDTH_Z;
      for (int i = 0; i < WIDTH; i++)
         if (DATA[i]) lz_v = ZW'(WIDTH-1-i);
      for (int i = WIDTH-1; i >= 0; i--)
         if (DATA[i]) tz_v = ZW'(i);
   end

   always_comb begin
      accept    = IVALID && IREADY;
      first     = (state_q == IDLE);
      last      = (idx_q == LAST_IDX);
      eff_mode  = first ? MODE : mode_q;
      cnt_cur   = first ? '0 : cnt_q;
      found_cur = first ? 1'b0 : found_q;

      cnt_nx   = cnt_cur;
      found_nx = found_cur;
      if (!eff_mode) begin
         if (!found_cur) begin
            if (DATA == '0) begin
               cnt_nx = cnt_cur + WIDTH_Z;
            end else begin
               cnt_nx   = cnt_cur + lz_v;
               found_nx = 1'b1;
            end
         end
      end else begin
         // A nonzero word restarts the trailing count from its own tz.
         cnt_nx = (DATA == '0) ? (cnt_cur + WIDTH_Z) : tz_v;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      found_d   = found_q;
      mode_d    = mode_q;
      ovalid_d  = ovalid_q && !OREADY;
      zeros_d   = zeros_q;
      allzero_d = allzero_q;
      if (accept) begin
         if (first) mode_d = MODE;
         if (last) begin
            state_d   = IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            found_d   = 1'b0;
            ovalid_d  = 1'b1;
            zeros_d   = cnt_nx;
            allzero_d = (cnt_nx == TOTAL);
         end else begin
            state_d = ACC;
            idx_d   = idx_q + 1'b1;
            cnt_d   = cnt_nx;
            found_d = found_nx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         found_q   <= 1'b0;
         mode_q    <= 1'b0;
         ovalid_q  <= 1'b0;
         zeros_q   <= '0;
         allzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         found_q   <= found_d;
         mode_q    <= mode_d;
         ovalid_q  <= ovalid_d;
         zeros_q   <= zeros_d;
         allzero_q <= allzero_d;
      end
   end

endmodule

// File: tb/tb_lzc_stream.sv
// Scoreboard bench for lzc_stream (WIDTH=8, WORD=4): stimulus pushes expected
// results, a monitor pops and compares on every output handshake.
module tb_lzc_stream;

   localparam int WIDTH = 8;
   localparam int WORD  = 4;
   localparam int ZW    = 6;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             IVALID = 1'b0;
   logic             IREADY;
   logic [WIDTH-1:0] DATA = '0;
   logic             MODE = 1'b0;
   logic             OVALID;
   logic             OREADY = 1'b1;
   logic [ZW-1:0]    ZEROS;
   logic             ALLZERO;

   int total = 0;
   int bad   = 0;
   logic [ZW:0] exp_q[$];

   lzc_stream #(.WIDTH(WIDTH), .WORD(WORD)) dut (
      .CLK(CLK), .RST(RST), .IVALID(IVALID), .IREADY(IREADY), .DATA(DATA),
      .MODE(MODE), .OVALID(OVALID), .OREADY(OREADY), .ZEROS(ZEROS), .ALLZERO(ALLZERO)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; returns 1 unit after the accepting edge.
   task automatic send_word(input logic [7:0] d, input logic m);
      int w;
      IVALID = 1'b1;
      DATA   = d;
      MODE   = m;
      w      = 0;
      @(negedge CLK);
      while (!IREADY && w < 500) begin
         @(negedge CLK);
         w++;
      end
      if (!IREADY) begin
         total++;
         bad++;
         $display("FAIL send_timeout: IREADY stuck at %0d, expected 1", IREADY);
      end
      @(posedge CLK);
      #1;
      IVALID = 1'b0;
   endtask

   task automatic send_group(input logic [31:0] words, input logic [3:0] modes,
                             input int ez, input logic ea);
      exp_q.push_back({ea, ZW'(ez)});
      for (int i = 0; i < 4; i++)
         send_word(words[31-8*i -: 8], modes[3-i]);
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge CLK);
         w++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: consumes every accepted result.
   initial begin
      logic [ZW:0] e;
      forever begin
         @(negedge CLK);
         if (!RST && OVALID && OREADY) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got zeros=%0d allzero=%0d, expected none", ZEROS, ALLZERO);
            end else begin
               e = exp_q.pop_front();
               check("zeros", ZEROS, e[ZW-1:0]);
               check("allzero", ALLZERO, e[ZW]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("rst_ovalid", OVALID, 0);
      check("rst_zeros", ZEROS, 0);
      check("rst_allzero", ALLZERO, 0);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      check("idle_iready", IREADY, 1);

      // 1: leading zeros 8+8+3, registered one cycle after the last word
      exp_q.push_back({1'b0, 6'd19});
      send_word(8'h00, 1'b0);
      send_word(8'h00, 1'b0);
      send_word(8'h1F, 1'b0);
      check("t1_no_early_valid", OVALID, 0);
      send_word(8'hFF, 1'b0);
      check("t1_latency_valid", OVALID, 1);

      // 2: all-zero group in both modes, back to back
      send_group(32'h00000000, 4'b0000, 32, 1'b1);
      send_group(32'h00000000, 4'b1111, 32, 1'b1);

      // 3: trailing zeros, including restart on later nonzero words
      send_group(32'h80000000, 4'b1111, 31, 1'b0);
      send_group(32'h00000110, 4'b1111, 4, 1'b0);

      // 4: mode latched on word 0 only
      send_group(32'h40FFFFFF, 4'b0111, 1, 1'b0);
      drain("drain_t4");

      // 5: backpressure holds A and stalls B
      @(posedge CLK);
      #1;
      OREADY = 1'b0;
      send_group(32'h01FFFFFF, 4'b0000, 7, 1'b0);
      check("t5_a_valid", OVALID, 1);
      fork
         send_group(32'h00000080, 4'b0000, 24, 1'b0);
         begin
            repeat (3) @(posedge CLK);
            #1;
            check("t5_iready_low", IREADY, 0);
            check("t5_a_held", ZEROS, 7);
            OREADY = 1'b1;
         end
      join
      drain("drain_t5");

      // 6: reset mid-group discards the partial group
      send_word(8'hFF, 1'b1);
      send_word(8'hFF, 1'b1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check("t6_rst_ovalid", OVALID, 0);
      check("t6_rst_zeros", ZEROS, 0);
      check("t6_rst_allzero", ALLZERO, 0);
      send_group(32'h00080000, 4'b0000, 12, 1'b0);
      drain("drain_t6");

      repeat (3) @(posedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
